// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned OS_RATE = 16;
  localparam int unsigned TICK_W  = 4;

  localparam logic [TICK_W-1:0] TICK_S0   = 4'd7;
  localparam logic [TICK_W-1:0] TICK_S1   = 4'd8;
  localparam logic [TICK_W-1:0] TICK_S2   = 4'd9;
  localparam logic [TICK_W-1:0] TICK_LAST = 4'd15;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic break_det;
  } rx_flags_t;

  // Clock cycles per oversample tick; zero means the clock is too slow.
  function automatic int unsigned os_div(input int unsigned clk_freq,
                                         input int unsigned baud_rate);
    return clk_freq / (baud_rate * OS_RATE);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Free-running 16x oversample tick generator with a synchronous phase restart.
module uart_os_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || (cnt == CNT_MAX)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_c = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver: 16x oversampling, 3-sample majority vote, optional parity,
// single-entry output register with valid/ready handshake and overrun flag.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9_600,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned DO_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rx,
  input  logic                dout_rdy,
  output logic [DO_WIDTH-1:0] dout,
  output logic                dout_vld,
  output logic                parity_err,
  output logic                frame_err,
  output logic                break_det,
  output logic                overrun,
  output logic                busy
);

  localparam int unsigned OS_DIV = os_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned BIT_W  = $clog2(DO_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DO_WIDTH - 1);
  localparam bit HAS_PAR = (PARITY != PAR_NONE);
  localparam bit ODD_PAR = (PARITY == PAR_ODD);

  if (OS_DIV < 1) begin : g_div_chk
    $error("uart_rx_os: CLK_FREQ too low for 16x oversampling of BAUD_RATE");
  end
  if ((DO_WIDTH < 5) || (DO_WIDTH > 9)) begin : g_width_chk
    $error("uart_rx_os: DO_WIDTH must be 5..9");
  end

  rx_state_e           state, state_next;
  logic                rx_s1, rx_s2, rx_prev;
  logic                start_c, tick_c, maj_c, at_mid_c, at_end_c;
  logic                restart_c, shift_c, par_c, load_c, exp_par_c;
  logic [TICK_W-1:0]   tcnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic                s0, s1;
  logic [DO_WIDTH-1:0] shreg;
  logic                par_err_q, par_low_q;
  rx_flags_t           flags_q, flags_c;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign start_c = rx_prev & ~rx_s2;

  uart_os_tick #(.DIV(OS_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_c),
    .tick_c  (tick_c)
  );

  assign at_mid_c  = tick_c && (tcnt == TICK_S2);
  assign at_end_c  = tick_c && (tcnt == TICK_LAST);
  assign maj_c     = (s0 & s1) | (s0 & rx_s2) | (s1 & rx_s2);
  assign exp_par_c = ODD_PAR ? ~(^shreg) : ^shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_c) state_next = ST_START;
      ST_START: begin
        if (at_mid_c && maj_c) state_next = ST_IDLE;
        else if (at_end_c)     state_next = ST_DATA;
      end
      ST_DATA: begin
        if (at_end_c && (bit_cnt == LAST_BIT))
          state_next = HAS_PAR ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (at_end_c) state_next = ST_STOP;
      ST_STOP:   if (at_mid_c) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Per-state strobes; the stop bit is decided at its mid-sample, not its end.
  always_comb begin
    restart_c = 1'b0;
    shift_c   = 1'b0;
    par_c     = 1'b0;
    load_c    = 1'b0;
    case (state)
      ST_IDLE:   restart_c = start_c;
      ST_DATA:   shift_c   = at_mid_c;
      ST_PARITY: par_c     = at_mid_c;
      ST_STOP:   load_c    = at_mid_c;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt    <= '0;
      bit_cnt <= '0;
      s0      <= 1'b1;
      s1      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      if (restart_c || (state_next == ST_IDLE)) tcnt <= '0;
      else if (tick_c)                          tcnt <= tcnt + TICK_W'(1);
      if (tick_c && (tcnt == TICK_S0)) s0 <= rx_s2;
      if (tick_c && (tcnt == TICK_S1)) s1 <= rx_s2;
      if (state != ST_DATA) bit_cnt <= '0;
      else if (at_end_c)    bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      par_err_q <= 1'b0;
      par_low_q <= 1'b1;
    end else begin
      if (shift_c) shreg <= {maj_c, shreg[DO_WIDTH-1:1]};
      if (restart_c) begin
        par_err_q <= 1'b0;
        par_low_q <= 1'b1;
      end else if (par_c) begin
        par_err_q <= maj_c ^ exp_par_c;
        par_low_q <= ~maj_c;
      end
    end
  end

  always_comb begin
    flags_c            = '0;
    flags_c.parity_err = par_err_q;
    flags_c.frame_err  = ~maj_c;
    flags_c.break_det  = ~maj_c && (shreg == '0) && par_low_q;
  end

  // Single-entry output register: a pending unaccepted frame wins over a new one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      flags_q  <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load_c && dout_vld && !dout_rdy) begin
        overrun <= 1'b1;
      end else if (load_c) begin
        dout     <= shreg;
        flags_q  <= flags_c;
        dout_vld <= 1'b1;
      end else if (dout_vld && dout_rdy) begin
        dout_vld <= 1'b0;
      end
    end
  end

  assign parity_err = flags_q.parity_err;
  assign frame_err  = flags_q.frame_err;
  assign break_det  = flags_q.break_det;

endmodule
